// File: rtl/vec_exec_unit_pkg.sv
// Shared CVP14 vector-unit definitions: opcodes, FSM states and the saturating clamp.
package cvp14_pkg;

  localparam logic [1:0] OP_VADD = 2'b00;
  localparam logic [1:0] OP_VDOT = 2'b01;
  localparam logic [1:0] OP_SMUL = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } ExecState;

  // Clamp a wide exact value into the signed w-bit range; ovf/unf report which bound was hit.
  function automatic logic signed [63:0] satW(input logic signed [63:0] x, input int w,
                                              output logic ovf, output logic unf);
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    maxV = (64'sd1 <<< (w - 1)) - 64'sd1;
    minV = -(64'sd1 <<< (w - 1));
    ovf  = 1'b0;
    unf  = 1'b0;
    satW = x;
    if (x > maxV) begin
      satW = maxV;
      ovf  = 1'b1;
    end else if (x < minV) begin
      satW = minV;
      unf  = 1'b1;
    end
  endfunction

endpackage

// File: rtl/vec_exec_unit_if.sv
// Request/result bundle between the CPU issue logic and the vector execution unit.
interface vec_exec_unit_if #(
  parameter int W    = 16,
  parameter int VLEN = 16
);
  logic                Start;
  logic [1:0]          Op;
  logic [VLEN*W-1:0]   VecA;
  logic [VLEN*W-1:0]   VecB;
  logic [W-1:0]        Scalar;
  logic                Busy;
  logic                Done;
  logic [VLEN*W-1:0]   VecOut;
  logic [W-1:0]        SOut;
  logic                V;
  logic                U;

  modport master (
    output Start, Op, VecA, VecB, Scalar,
    input  Busy, Done, VecOut, SOut, V, U
  );

  modport slave (
    input  Start, Op, VecA, VecB, Scalar,
    output Busy, Done, VecOut, SOut, V, U
  );
endinterface

// File: rtl/vec_exec_unit_lane.sv
// One element lane: saturating add or scalar multiply, plus the exact product for dot products.
module vec_lane
  import cvp14_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [1:0]            op,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  input  logic signed [W-1:0]   scalar,
  output logic signed [W-1:0]   res,
  output logic signed [2*W-1:0] prod,
  output logic                  ovf,
  output logic                  unf
);

  logic signed [W:0]  sum;
  logic signed [63:0] clamped;
  logic               satHi;
  logic               satLo;
  logic               unusedHigh;

  always_comb begin
    sum  = (W+1)'(a) + (W+1)'(b);
    // The same multiplier serves VDOT (a*b) and SMUL (a*scalar).
    prod = (op == OP_VDOT) ? (2*W)'(a) * (2*W)'(b) : (2*W)'(a) * (2*W)'(scalar);
    if (op == OP_VADD) begin
      clamped = satW(64'(sum), W, satHi, satLo);
    end else begin
      clamped = satW(64'(prod), W, satHi, satLo);
    end
    res = clamped[W-1:0];
    ovf = satHi && (op != OP_VDOT);
    unf = satLo && (op != OP_VDOT);
  end

  assign unusedHigh = &{1'b0, clamped[63:W]};

endmodule

// File: rtl/vec_exec_unit.sv
// Multi-cycle vector execution unit: VADD, VDOT and SMUL over VLEN elements, NLANES per beat.
module vec_exec_unit
  import cvp14_pkg::*;
#(
  parameter int W      = 16,
  parameter int VLEN   = 16,
  parameter int NLANES = 4
) (
  input logic             Clk1,
  input logic             Reset,
  vec_exec_unit_if.slave  bus
);

  localparam int BEATS = VLEN / NLANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ACC_W = 2*W + $clog2(VLEN);

  if (VLEN % NLANES != 0) begin : gBadLanes
    $error("vec_exec_unit: VLEN must be a multiple of NLANES");
  end
  if (ACC_W > 64) begin : gBadWidth
    $error("vec_exec_unit: accumulator wider than 64 bits");
  end

  ExecState                state;
  logic [BW-1:0]           beat;
  logic [1:0]              opReg;
  logic [VLEN*W-1:0]       aReg;
  logic [VLEN*W-1:0]       bReg;
  logic signed [W-1:0]     scalarReg;
  logic signed [ACC_W-1:0] acc;

  logic signed [W-1:0]     laneA    [NLANES];
  logic signed [W-1:0]     laneB    [NLANES];
  logic signed [W-1:0]     laneRes  [NLANES];
  logic signed [2*W-1:0]   laneProd [NLANES];
  logic                    laneOvf  [NLANES];
  logic                    laneUnf  [NLANES];

  logic signed [ACC_W-1:0] beatSum;
  logic signed [ACC_W-1:0] total;
  logic signed [63:0]      dotClamp;
  logic                    dotOvf;
  logic                    dotUnf;
  logic                    anyOvf;
  logic                    anyUnf;
  logic                    lastBeat;
  logic                    startOk;
  logic                    unusedHigh;

  always_comb begin
    for (int l = 0; l < NLANES; l++) begin
      laneA[l] = aReg[(int'(beat)*NLANES + l)*W +: W];
      laneB[l] = bReg[(int'(beat)*NLANES + l)*W +: W];
    end
  end

  for (genvar g = 0; g < NLANES; g++) begin : gLane
    vec_lane #(.W(W)) uLane (
      .op     (opReg),
      .a      (laneA[g]),
      .b      (laneB[g]),
      .scalar (scalarReg),
      .res    (laneRes[g]),
      .prod   (laneProd[g]),
      .ovf    (laneOvf[g]),
      .unf    (laneUnf[g])
    );
  end

  // Dot-product accumulation is exact; only the final total is clamped.
  always_comb begin
    beatSum = '0;
    anyOvf  = 1'b0;
    anyUnf  = 1'b0;
    for (int l = 0; l < NLANES; l++) begin
      beatSum = beatSum + ACC_W'(laneProd[l]);
      anyOvf  = anyOvf | laneOvf[l];
      anyUnf  = anyUnf | laneUnf[l];
    end
    total    = acc + beatSum;
    dotClamp = satW(64'(total), W, dotOvf, dotUnf);
  end

  assign unusedHigh = &{1'b0, dotClamp[63:W]};
  assign lastBeat   = (beat == BW'(BEATS - 1));
  assign startOk    = bus.Start && (bus.Op != OP_RSVD);

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state      <= ST_IDLE;
      beat       <= '0;
      bus.Busy   <= 1'b0;
      bus.Done   <= 1'b0;
      bus.V      <= 1'b0;
      bus.U      <= 1'b0;
      bus.VecOut <= '0;
      bus.SOut   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          bus.Done <= 1'b0;
          if (startOk) begin
            state      <= ST_RUN;
            bus.Busy   <= 1'b1;
            beat       <= '0;
            acc        <= '0;
            opReg      <= bus.Op;
            aReg       <= bus.VecA;
            bReg       <= bus.VecB;
            scalarReg  <= bus.Scalar;
            bus.VecOut <= '0;
            bus.SOut   <= '0;
            bus.V      <= 1'b0;
            bus.U      <= 1'b0;
          end else begin
            state    <= ST_IDLE;
            bus.Busy <= 1'b0;
          end
        end
        ST_RUN: begin
          if (opReg == OP_VDOT) begin
            acc <= total;
            if (lastBeat) begin
              bus.SOut <= dotClamp[W-1:0];
              bus.V    <= bus.V | dotOvf;
              bus.U    <= bus.U | dotUnf;
            end
          end else begin
            for (int l = 0; l < NLANES; l++) begin
              bus.VecOut[(int'(beat)*NLANES + l)*W +: W] <= laneRes[l];
            end
            bus.V <= bus.V | anyOvf;
            bus.U <= bus.U | anyUnf;
          end
          if (lastBeat) begin
            state    <= ST_DONE;
            bus.Busy <= 1'b0;
            bus.Done <= 1'b1;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_exec_unit.sv
// Directed bench for vec_exec_unit with W=16, VLEN=8, NLANES=2 (four beats per operation).
module tb_vec_exec_unit;
  import cvp14_pkg::*;

  localparam int W      = 16;
  localparam int VLEN   = 8;
  localparam int NLANES = 2;

  logic clk = 1'b0;
  logic rst;
  int   nCmp = 0;
  int   nBad = 0;

  vec_exec_unit_if #(.W(W), .VLEN(VLEN)) bus ();

  vec_exec_unit #(.W(W), .VLEN(VLEN), .NLANES(NLANES)) dut (
    .Clk1  (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [W-1:0] elem(input logic [VLEN*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  // Issue one request and leave the bench in its Done cycle; doneAt is -1 on timeout.
  task automatic runOp(input logic [1:0] op, input logic [VLEN*W-1:0] a,
                       input logic [VLEN*W-1:0] b, input logic [W-1:0] s, output int doneAt);
    bus.Op = op; bus.VecA = a; bus.VecB = b; bus.Scalar = s; bus.Start = 1'b1;
    tick;
    bus.Start = 1'b0;
    doneAt = -1;
    for (int c = 1; c <= 20; c++) begin
      if (bus.Done === 1'b1) begin
        doneAt = c;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.Start = 1'b0; bus.Op = OP_VADD;
    bus.VecA = '0; bus.VecB = '0; bus.Scalar = '0;
    tick; tick;
    nCmp++; if (bus.Busy !== 1'b0) begin nBad++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    nCmp++; if (bus.Done !== 1'b0) begin nBad++; $display("FAIL reset_done got %b want 0", bus.Done); end
    nCmp++; if ({bus.V, bus.U} !== 2'b00) begin nBad++; $display("FAIL reset_flags got %b want 00", {bus.V, bus.U}); end
    nCmp++; if (bus.VecOut !== '0) begin nBad++; $display("FAIL reset_vecout got %h want 0", bus.VecOut); end
    nCmp++; if (bus.SOut !== '0) begin nBad++; $display("FAIL reset_sout got %h want 0", bus.SOut); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_vadd;
    logic [VLEN*W-1:0] a, b;
    for (int i = 0; i < VLEN; i++) begin a[i*W +: W] = W'(i); b[i*W +: W] = W'(100); end
    bus.Op = OP_VADD; bus.VecA = a; bus.VecB = b; bus.Start = 1'b1;
    tick;
    bus.Start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      nCmp++;
      if (bus.Busy !== (c <= 4)) begin nBad++; $display("FAIL vadd_busy cycle %0d got %b want %b", c, bus.Busy, (c <= 4)); end
      nCmp++;
      if (bus.Done !== (c == 5)) begin nBad++; $display("FAIL vadd_done cycle %0d got %b want %b", c, bus.Done, (c == 5)); end
      if (c < 5) tick;
    end
    for (int i = 0; i < VLEN; i++) begin
      nCmp++;
      if (elem(bus.VecOut, i) !== W'(100 + i)) begin
        nBad++; $display("FAIL vadd_out[%0d] got %0d want %0d", i, elem(bus.VecOut, i), 100 + i);
      end
    end
    nCmp++; if ({bus.V, bus.U} !== 2'b00) begin nBad++; $display("FAIL vadd_flags got %b want 00", {bus.V, bus.U}); end
    tick;
    nCmp++; if (bus.Done !== 1'b0) begin nBad++; $display("FAIL vadd_done_pulse got %b want 0", bus.Done); end
    nCmp++; if (elem(bus.VecOut, 3) !== W'(103)) begin nBad++; $display("FAIL vadd_hold got %0d want 103", elem(bus.VecOut, 3)); end
  endtask

  task automatic test_vadd_sat;
    logic [VLEN*W-1:0] a, b;
    int d;
    for (int i = 0; i < VLEN; i++) begin a[i*W +: W] = W'(32767); b[i*W +: W] = W'(1); end
    runOp(OP_VADD, a, b, '0, d);
    nCmp++; if (d != 5) begin nBad++; $display("FAIL vsat_latency got %0d want 5", d); end
    for (int i = 0; i < VLEN; i++) begin
      nCmp++;
      if (elem(bus.VecOut, i) !== 16'sd32767) begin nBad++; $display("FAIL vsat_out[%0d] got %0d want 32767", i, elem(bus.VecOut, i)); end
    end
    nCmp++; if ({bus.V, bus.U} !== 2'b10) begin nBad++; $display("FAIL vsat_flags got %b want 10", {bus.V, bus.U}); end
    tick;
    runOp(OP_VADD, '0, '0, '0, d);
    nCmp++; if (bus.VecOut !== '0) begin nBad++; $display("FAIL vzero_out got %h want 0", bus.VecOut); end
    nCmp++; if ({bus.V, bus.U} !== 2'b00) begin nBad++; $display("FAIL vzero_flags got %b want 00", {bus.V, bus.U}); end
    tick;
    // Sums landing exactly on a bound: even lanes hit +max, odd lanes hit -min.
    for (int i = 0; i < VLEN; i++) begin
      a[i*W +: W] = (i % 2 == 0) ? W'(32766) : W'(-32767);
      b[i*W +: W] = (i % 2 == 0) ? W'(1) : W'(-1);
    end
    runOp(OP_VADD, a, b, '0, d);
    nCmp++; if (elem(bus.VecOut, 0) !== 16'sd32767) begin nBad++; $display("FAIL vbound_hi got %0d want 32767", elem(bus.VecOut, 0)); end
    nCmp++; if (elem(bus.VecOut, 7) !== 16'sh8000) begin nBad++; $display("FAIL vbound_lo got %0d want -32768", elem(bus.VecOut, 7)); end
    nCmp++; if ({bus.V, bus.U} !== 2'b00) begin nBad++; $display("FAIL vbound_flags got %b want 00", {bus.V, bus.U}); end
    tick;
  endtask

  task automatic test_smul;
    logic [VLEN*W-1:0] a;
    int d;
    for (int i = 0; i < VLEN; i++) a[i*W +: W] = W'(-300);
    runOp(OP_SMUL, a, '0, W'(200), d);
    nCmp++; if (d != 5) begin nBad++; $display("FAIL smul_latency got %0d want 5", d); end
    for (int i = 0; i < VLEN; i++) begin
      nCmp++;
      if (elem(bus.VecOut, i) !== 16'sh8000) begin nBad++; $display("FAIL smul_out[%0d] got %0d want -32768", i, elem(bus.VecOut, i)); end
    end
    nCmp++; if ({bus.V, bus.U} !== 2'b01) begin nBad++; $display("FAIL smul_flags got %b want 01", {bus.V, bus.U}); end
    tick;
    for (int i = 0; i < VLEN; i++) a[i*W +: W] = (i == 0) ? 16'sh8000 : W'(10 * i);
    runOp(OP_SMUL, a, '0, W'(-1), d);
    nCmp++; if (elem(bus.VecOut, 0) !== 16'sd32767) begin nBad++; $display("FAIL smul_neg_out[0] got %0d want 32767", elem(bus.VecOut, 0)); end
    nCmp++; if (elem(bus.VecOut, 5) !== W'(-50)) begin nBad++; $display("FAIL smul_neg_out[5] got %0d want -50", elem(bus.VecOut, 5)); end
    nCmp++; if ({bus.V, bus.U} !== 2'b10) begin nBad++; $display("FAIL smul_neg_flags got %b want 10", {bus.V, bus.U}); end
    tick;
  endtask

  task automatic test_vdot;
    logic [VLEN*W-1:0] a, b;
    int d;
    for (int i = 0; i < VLEN; i++) begin a[i*W +: W] = W'(1000); b[i*W +: W] = W'(1000); end
    runOp(OP_VDOT, a, b, '0, d);
    nCmp++; if (d != 5) begin nBad++; $display("FAIL vdot_latency got %0d want 5", d); end
    nCmp++; if (bus.SOut !== 16'sd32767) begin nBad++; $display("FAIL vdot_sat_sout got %0d want 32767", $signed(bus.SOut)); end
    nCmp++; if ({bus.V, bus.U} !== 2'b10) begin nBad++; $display("FAIL vdot_sat_flags got %b want 10", {bus.V, bus.U}); end
    nCmp++; if (bus.VecOut !== '0) begin nBad++; $display("FAIL vdot_vecout got %h want 0", bus.VecOut); end
    tick;
    for (int i = 0; i < VLEN; i++) begin a[i*W +: W] = W'(i); b[i*W +: W] = W'(2); end
    runOp(OP_VDOT, a, b, '0, d);
    nCmp++; if (bus.SOut !== W'(56)) begin nBad++; $display("FAIL vdot_small_sout got %0d want 56", $signed(bus.SOut)); end
    nCmp++; if ({bus.V, bus.U} !== 2'b00) begin nBad++; $display("FAIL vdot_small_flags got %b want 00", {bus.V, bus.U}); end
    tick;
    for (int i = 0; i < VLEN; i++) begin a[i*W +: W] = W'(-1000); b[i*W +: W] = W'(1000); end
    runOp(OP_VDOT, a, b, '0, d);
    nCmp++; if (bus.SOut !== 16'sh8000) begin nBad++; $display("FAIL vdot_neg_sout got %0d want -32768", $signed(bus.SOut)); end
    nCmp++; if ({bus.V, bus.U} !== 2'b01) begin nBad++; $display("FAIL vdot_neg_flags got %b want 01", {bus.V, bus.U}); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [VLEN*W-1:0] a1, a2, b2, out2;
    int count, first, second;
    for (int i = 0; i < VLEN; i++) begin
      a1[i*W +: W] = W'(1); a2[i*W +: W] = W'(i); b2[i*W +: W] = W'(3 * i);
    end
    count = 0; first = -1; second = -1; out2 = '0;
    bus.Op = OP_VADD; bus.VecA = a1; bus.VecB = a1; bus.Start = 1'b1;
    tick;
    for (int c = 1; c <= 14; c++) begin
      if (bus.Done === 1'b1) begin
        count++;
        if (count == 1) first = c;
        if (count == 2) begin second = c; out2 = bus.VecOut; end
      end
      if (c == 5) begin bus.VecA = a2; bus.VecB = b2; end
      if (c == 6) bus.Start = 1'b0;
      tick;
    end
    nCmp++; if (count != 2) begin nBad++; $display("FAIL b2b_count got %0d want 2", count); end
    nCmp++; if (first != 5) begin nBad++; $display("FAIL b2b_first got %0d want 5", first); end
    nCmp++; if (second != 10) begin nBad++; $display("FAIL b2b_second got %0d want 10", second); end
    nCmp++; if (elem(out2, 6) !== W'(24)) begin nBad++; $display("FAIL b2b_out[6] got %0d want 24", elem(out2, 6)); end
  endtask

  task automatic test_reset_mid;
    logic [VLEN*W-1:0] a, b;
    int dones;
    logic sawBusy, sawDone;
    for (int i = 0; i < VLEN; i++) begin a[i*W +: W] = W'(32767); b[i*W +: W] = W'(1); end
    bus.Op = OP_VADD; bus.VecA = a; bus.VecB = b; bus.Start = 1'b1;
    tick;
    bus.Start = 1'b0;
    tick; tick;
    nCmp++; if (bus.V !== 1'b1) begin nBad++; $display("FAIL mid_v_before got %b want 1", bus.V); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    nCmp++; if ({bus.Busy, bus.Done} !== 2'b00) begin nBad++; $display("FAIL mid_ctrl got %b want 00", {bus.Busy, bus.Done}); end
    nCmp++; if (bus.VecOut !== '0) begin nBad++; $display("FAIL mid_vecout got %h want 0", bus.VecOut); end
    nCmp++; if ({bus.V, bus.U} !== 2'b00) begin nBad++; $display("FAIL mid_flags got %b want 00", {bus.V, bus.U}); end
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.Done === 1'b1) dones++;
      tick;
    end
    nCmp++; if (dones != 0) begin nBad++; $display("FAIL mid_no_done got %0d want 0", dones); end
    bus.Op = OP_RSVD; bus.Start = 1'b1;
    sawBusy = 1'b0; sawDone = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      sawBusy = sawBusy | bus.Busy;
      sawDone = sawDone | bus.Done;
    end
    bus.Start = 1'b0;
    nCmp++; if (sawBusy !== 1'b0) begin nBad++; $display("FAIL rsvd_busy got %b want 0", sawBusy); end
    nCmp++; if (sawDone !== 1'b0) begin nBad++; $display("FAIL rsvd_done got %b want 0", sawDone); end
  endtask

  initial begin
    test_reset();
    test_vadd();
    test_vadd_sat();
    test_smul();
    test_vdot();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
